hex_syscall_unit: RTL and testbench
===================================

// Module: hex_syscall_unit
// PURPOSE
// Downstream of the processor's syscall interface. It executes SVC requests (EXIT, WRITE, READ) as
// a multi-cycle sequence:
// - reads the stack pointer and arguments from data memory;
// - drives byte-wide output/input stream handshakes;
// - writes READ results back to memory.
// It stalls the processor for the whole sequence. Top level arbitrates the data memory port
// (processor has priority while o_stall=0).
// PARAMETERS
// ADDR_W   18  byte address width (= hex_pkg::addr_t)
// DATA_W   32  data word width (= hex_pkg::data_t)
// SP_ADDR  4   byte address of the stack-pointer word
// PORTS
// i_clk           in   1       clock, rising edge
// i_rst           in   1       reset, asynchronous, active-high
// i_syscall_valid in   1       processor executing SVC this cycle
// i_syscall       in   syscall_t  code: EXIT=0, WRITE=1, READ=2
// o_stall         out  1       hold processor state (pc/areg/breg/oreg)
// o_d_valid       out  1       memory request
// o_d_we          out  1       1=write, 0=read
// o_d_addr        out  ADDR_W  byte address
// o_d_data        out  DATA_W  write data
// i_d_data        in   DATA_W  read data, valid the cycle after a read request
// o_out_valid     out  1       output byte valid
// o_out_data      out  8       output byte
// o_out_stream    out  8       output stream id
// i_out_ready     in   1       output sink accepts
// o_in_req        out  1       request one input byte
// o_in_stream     out  8       input stream id
// i_in_valid      in   1       input byte present
// i_in_data       in   8       input byte
// o_exit          out  1       sticky: program exited
// o_exit_code     out  DATA_W  EXIT argument
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; sp/arg1/arg2 regs 0. Reset mid-sequence aborts silently;
//   no partial memory write survives.
// - Word index w maps to byte address (w<<2), computed in DATA_W and truncated to ADDR_W
//   (wraps, no error).
// - Argument layout: sp = mem[SP_ADDR]; arg1 at word sp+2; arg2 at word sp+3; result at word sp+1.
// - FSM, one state per cycle unless stated:
//   - IDLE: o_stall = i_syscall_valid (combinational). If valid -> RD_SP.
//   - RD_SP: read SP_ADDR -> RD_A1.
//   - RD_A1: latch sp <= i_d_data; read (sp+2)<<2 -> RD_A2.
//   - RD_A2: latch arg1. Dispatch:
//     - WRITE: read (sp+3)<<2 -> LAT_A2.
//     - READ -> IN_WAIT.
//     - EXIT -> HALT.
//     - Other code -> DONE (no-op).
//   - LAT_A2: latch arg2 -> OUT.
//   - OUT: o_out_valid=1, data=arg1[7:0], stream=arg2[7:0]; held stable until i_out_ready -> DONE.
//   - IN_WAIT: o_in_req=1, stream=arg1[7:0]. On i_in_valid: latch byte -> STORE.
//   - STORE: write {24'b0,byte} to (sp+1)<<2 (we=1, one cycle) -> DONE.
//   - HALT: o_exit=1, o_exit_code=arg1, o_stall=1; terminal until reset.
//   - DONE: o_stall=0, i_syscall_valid ignored (processor retires SVC this cycle) -> IDLE.
// - o_stall=1 in every state except IDLE (see above) and DONE.
// - Memory outputs are 0 when o_d_valid=0.
// - Latency from valid (cycle 0):
//   - WRITE: first o_out_valid at cycle 5.
//   - READ: o_in_req at cycle 4.
//   - EXIT: o_exit at cycle 4.
// - Back-to-back SVCs: DONE guarantees exactly one execution per SVC.
// - A held output/input handshake never times out.
// STRUCTURE
// - hex_pkg gains: SP_ADDR constant, SYS_EXIT/SYS_WRITE/SYS_READ in syscall_t,
//   sys_state_t enum (IDLE..DONE).
// - Single flat module (FSM + three data regs + stream latch); no sub-module.
// TESTING
// - WRITE: mem[4]=100, mem[408]=0x41, mem[412]=0, ready=1
//   -> out_valid at cycle 5, data 0x41, stream 0; stall drops at DONE.
// - Backpressure: same WRITE, ready low 6 cycles
//   -> out_valid/data/stream stable all 6 cycles; single transfer on ready.
// - READ: mem[4]=50, mem[208]=1, in byte 0x5A after 3 cycles
//   -> in_stream=1; write 0x0000005A to addr 204.
// - EXIT: mem[4]=10, mem[48]=3
//   -> o_exit=1, o_exit_code=3, stall held 20+ cycles.
// - i_syscall_valid held high across DONE
//   -> exactly one out byte per SVC, IDLE re-entered.
// - Reset asserted in IN_WAIT
//   -> all outputs 0 immediately; no memory write; next SVC runs normally.

Source files
------------

// File: rtl/hex_syscall_unit_pkg.sv
// Shared types for the syscall unit: bus widths, syscall codes, FSM states and
// the word-index to byte-address helper.
package hex_syscall_unit_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam addr_t SP_ADDR = 18'd4;

  typedef enum logic [1:0] {
    SYS_EXIT  = 2'd0,
    SYS_WRITE = 2'd1,
    SYS_READ  = 2'd2
  } syscall_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_SP,
    RD_A1,
    RD_A2,
    LAT_A2,
    OUT,
    IN_WAIT,
    STORE,
    HALT,
    DONE
  } sys_state_t;

  // Word index to byte address; the shift happens at full data width, then wraps into the address space.
  function automatic addr_t wordAddr(input data_t w);
    data_t b;
    b = w << 2;
    return b[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/hex_syscall_unit_if.sv
// Bundles the syscall request, data-memory port and byte-stream handshakes.
// The master side is the syscall unit; the slave side is processor, memory and streams.
interface hex_syscall_unit_if;
  import hex_syscall_unit_pkg::*;

  logic     i_syscall_valid;
  syscall_t i_syscall;
  logic     o_stall;

  logic     o_d_valid;
  logic     o_d_we;
  addr_t    o_d_addr;
  data_t    o_d_data;
  data_t    i_d_data;

  logic       o_out_valid;
  logic [7:0] o_out_data;
  logic [7:0] o_out_stream;
  logic       i_out_ready;

  logic       o_in_req;
  logic [7:0] o_in_stream;
  logic       i_in_valid;
  logic [7:0] i_in_data;

  logic  o_exit;
  data_t o_exit_code;

  modport master (
    input  i_syscall_valid, i_syscall, i_d_data, i_out_ready, i_in_valid, i_in_data,
    output o_stall, o_d_valid, o_d_we, o_d_addr, o_d_data,
    output o_out_valid, o_out_data, o_out_stream, o_in_req, o_in_stream,
    output o_exit, o_exit_code
  );

  modport slave (
    output i_syscall_valid, i_syscall, i_d_data, i_out_ready, i_in_valid, i_in_data,
    input  o_stall, o_d_valid, o_d_we, o_d_addr, o_d_data,
    input  o_out_valid, o_out_data, o_out_stream, o_in_req, o_in_stream,
    input  o_exit, o_exit_code
  );

endinterface

// File: rtl/hex_syscall_unit.sv
// Executes SVC requests (EXIT/WRITE/READ) as a multi-cycle sequence, stalling the
// processor while it fetches arguments, drives the byte streams and stores READ results.
module hex_syscall_unit
  import hex_syscall_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  hex_syscall_unit_if.master bus
);

  sys_state_t r_state;
  sys_state_t w_next;
  data_t      r_sp;
  data_t      r_arg1;
  logic [7:0] r_arg2;
  logic [7:0] r_byte;

  // Memory read data arrives one cycle after the request, so each latch happens in the state after its read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_sp    <= '0;
      r_arg1  <= '0;
      r_arg2  <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        RD_A1:   r_sp   <= bus.i_d_data;
        RD_A2:   r_arg1 <= bus.i_d_data;
        LAT_A2:  r_arg2 <= bus.i_d_data[7:0];
        IN_WAIT: if (bus.i_in_valid) r_byte <= bus.i_in_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.o_stall      = 1'b1;
    bus.o_d_valid    = 1'b0;
    bus.o_d_we       = 1'b0;
    bus.o_d_addr     = '0;
    bus.o_d_data     = '0;
    bus.o_out_valid  = 1'b0;
    bus.o_out_data   = '0;
    bus.o_out_stream = '0;
    bus.o_in_req     = 1'b0;
    bus.o_in_stream  = '0;
    bus.o_exit       = 1'b0;
    bus.o_exit_code  = '0;

    case (r_state)
      IDLE: begin
        // Gated by reset so a held SVC cannot leak a stall while reset is asserted.
        bus.o_stall = bus.i_syscall_valid && !i_rst;
        if (bus.i_syscall_valid) w_next = RD_SP;
      end
      RD_SP: begin
        bus.o_d_valid = 1'b1;
        bus.o_d_addr  = SP_ADDR;
        w_next        = RD_A1;
      end
      RD_A1: begin
        bus.o_d_valid = 1'b1;
        bus.o_d_addr  = wordAddr(bus.i_d_data + 32'd2);
        w_next        = RD_A2;
      end
      RD_A2: begin
        case (bus.i_syscall)
          SYS_WRITE: begin
            bus.o_d_valid = 1'b1;
            bus.o_d_addr  = wordAddr(r_sp + 32'd3);
            w_next        = LAT_A2;
          end
          SYS_READ: w_next = IN_WAIT;
          SYS_EXIT: w_next = HALT;
          default:  w_next = DONE;
        endcase
      end
      LAT_A2: w_next = OUT;
      OUT: begin
        bus.o_out_valid  = 1'b1;
        bus.o_out_data   = r_arg1[7:0];
        bus.o_out_stream = r_arg2;
        if (bus.i_out_ready) w_next = DONE;
      end
      IN_WAIT: begin
        bus.o_in_req    = 1'b1;
        bus.o_in_stream = r_arg1[7:0];
        if (bus.i_in_valid) w_next = STORE;
      end
      STORE: begin
        bus.o_d_valid = 1'b1;
        bus.o_d_we    = 1'b1;
        bus.o_d_addr  = wordAddr(r_sp + 32'd1);
        bus.o_d_data  = {24'b0, r_byte};
        w_next        = DONE;
      end
      HALT: begin
        bus.o_exit      = 1'b1;
        bus.o_exit_code = r_arg1;
      end
      DONE: begin
        // The processor retires the SVC here, so a still-high valid is not a new request.
        bus.o_stall = 1'b0;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_syscall_unit.sv
// Directed bench for hex_syscall_unit: word-addressed memory model, output sink
// and hand-computed expectations for WRITE, READ, EXIT, back-to-back and reset cases.
module tb_hex_syscall_unit;
  import hex_syscall_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   outCount    = 0;
  int   writeCount  = 0;
  logic [31:0] mem [0:65535];
  logic [31:0] rdData = '0;

  hex_syscall_unit_if bus();

  hex_syscall_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_d_data = rdData;

  // Synchronous memory: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (bus.o_d_valid) begin
      if (bus.o_d_we) begin
        mem[bus.o_d_addr[17:2]] <= bus.o_d_data;
        writeCount <= writeCount + 1;
      end else begin
        rdData <= mem[bus.o_d_addr[17:2]];
      end
    end
    if (bus.o_out_valid && bus.i_out_ready) outCount <= outCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input syscall_t code);
    @(negedge clk);
    bus.i_syscall_valid = 1'b1;
    bus.i_syscall       = code;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_syscall_valid = 1'b0;
    bus.i_syscall       = SYS_EXIT;
    bus.i_out_ready     = 1'b0;
    bus.i_in_valid      = 1'b0;
    bus.i_in_data       = 8'h00;
    mem[1]   <= 32'd100;
    mem[102] <= 32'h41;
    mem[103] <= 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall",  bus.o_stall, 0);
    checkOutput("rst_dvalid", bus.o_d_valid, 0);
    checkOutput("rst_out",    bus.o_out_valid, 0);
    checkOutput("rst_exit",   bus.o_exit, 0);
    @(negedge clk);
    rst = 1'b0;

    // WRITE with sink always ready
    bus.i_out_ready = 1'b1;
    applyStimulus(SYS_WRITE);
    #1 checkOutput("wr_c0_stall", bus.o_stall, 1);
    @(negedge clk); #1;
    checkOutput("wr_c1_dvalid", bus.o_d_valid, 1);
    checkOutput("wr_c1_addr",   bus.o_d_addr, 4);
    checkOutput("wr_c1_we",     bus.o_d_we, 0);
    @(negedge clk); #1 checkOutput("wr_c2_addr", bus.o_d_addr, 408);
    @(negedge clk); #1 checkOutput("wr_c3_addr", bus.o_d_addr, 412);
    @(negedge clk); #1 checkOutput("wr_c4_outv", bus.o_out_valid, 0);
    @(negedge clk); #1;
    checkOutput("wr_c5_outv",   bus.o_out_valid, 1);
    checkOutput("wr_c5_data",   bus.o_out_data, 8'h41);
    checkOutput("wr_c5_stream", bus.o_out_stream, 0);
    checkOutput("wr_c5_stall",  bus.o_stall, 1);
    @(negedge clk);
    bus.i_syscall_valid = 1'b0;
    #1;
    checkOutput("wr_c6_stall", bus.o_stall, 0);
    checkOutput("wr_c6_outv",  bus.o_out_valid, 0);
    checkOutput("wr_c6_count", outCount, 1);
    @(negedge clk); #1;
    checkOutput("wr_c7_stall",  bus.o_stall, 0);
    checkOutput("wr_c7_dvalid", bus.o_d_valid, 0);

    // WRITE with 6 cycles of backpressure, stream 7
    mem[103] <= 32'h7;
    bus.i_out_ready = 1'b0;
    applyStimulus(SYS_WRITE);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      checkOutput("bp_outv",   bus.o_out_valid, 1);
      checkOutput("bp_data",   bus.o_out_data, 8'h41);
      checkOutput("bp_stream", bus.o_out_stream, 8'h07);
    end
    bus.i_out_ready = 1'b1;
    @(negedge clk); #1;
    checkOutput("bp_done_outv",  bus.o_out_valid, 0);
    checkOutput("bp_done_stall", bus.o_stall, 0);
    checkOutput("bp_count",      outCount, 2);
    bus.i_syscall_valid = 1'b0;

    // valid held high across DONE: two SVCs, two bytes
    applyStimulus(SYS_WRITE);
    repeat (6) @(negedge clk);
    #1 checkOutput("b2b_c6_stall", bus.o_stall, 0);
    @(negedge clk); #1 checkOutput("b2b_c7_stall", bus.o_stall, 1);
    repeat (6) @(negedge clk);
    #1;
    checkOutput("b2b_c13_stall", bus.o_stall, 0);
    checkOutput("b2b_count",     outCount, 4);
    bus.i_syscall_valid = 1'b0;
    @(negedge clk); #1;
    checkOutput("b2b_idle_stall", bus.o_stall, 0);
    checkOutput("b2b_idle_dv",    bus.o_d_valid, 0);
    checkOutput("b2b_idle_count", outCount, 4);

    // READ aborted by reset in IN_WAIT
    mem[1]  <= 32'd50;
    mem[52] <= 32'd1;
    applyStimulus(SYS_READ);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rra_c4_req",    bus.o_in_req, 1);
    checkOutput("rra_c4_stream", bus.o_in_stream, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rra_req",    bus.o_in_req, 0);
    checkOutput("rra_stream", bus.o_in_stream, 0);
    checkOutput("rra_stall",  bus.o_stall, 0);
    checkOutput("rra_dvalid", bus.o_d_valid, 0);
    bus.i_syscall_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rra_writes", writeCount, 0);

    // READ with input byte after 3 waiting cycles
    applyStimulus(SYS_READ);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rd_c4_req",    bus.o_in_req, 1);
    checkOutput("rd_c4_stream", bus.o_in_stream, 1);
    @(negedge clk); #1 checkOutput("rd_c5_req", bus.o_in_req, 1);
    @(negedge clk); #1 checkOutput("rd_c6_req", bus.o_in_req, 1);
    @(negedge clk);
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = 8'h5A;
    #1 checkOutput("rd_c7_req", bus.o_in_req, 1);
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    #1;
    checkOutput("rd_st_dvalid", bus.o_d_valid, 1);
    checkOutput("rd_st_we",     bus.o_d_we, 1);
    checkOutput("rd_st_addr",   bus.o_d_addr, 204);
    checkOutput("rd_st_data",   bus.o_d_data, 32'h0000005A);
    @(negedge clk);
    bus.i_syscall_valid = 1'b0;
    #1;
    checkOutput("rd_done_stall", bus.o_stall, 0);
    checkOutput("rd_mem",        mem[51], 32'h0000005A);
    checkOutput("rd_writes",     writeCount, 1);

    // Unknown code 3 is a no-op
    mem[1] <= 32'd10;
    mem[12] <= 32'd3;
    applyStimulus(syscall_t'(2'd3));
    repeat (4) @(negedge clk);
    #1;
    checkOutput("nop_stall", bus.o_stall, 0);
    checkOutput("nop_exit",  bus.o_exit, 0);
    checkOutput("nop_outv",  bus.o_out_valid, 0);
    bus.i_syscall_valid = 1'b0;
    @(negedge clk);

    // EXIT: sticky halt until reset
    applyStimulus(SYS_EXIT);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("ex_c4_exit", bus.o_exit, 1);
    checkOutput("ex_c4_code", bus.o_exit_code, 3);
    bus.i_syscall_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      checkOutput("ex_hold", {30'b0, bus.o_stall, bus.o_exit}, 2'b11);
    end
    rst = 1'b1;
    #1;
    checkOutput("ex_rst_exit",  bus.o_exit, 0);
    checkOutput("ex_rst_code",  bus.o_exit_code, 0);
    checkOutput("ex_rst_stall", bus.o_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
